// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver, the decoder and the game logic.
interface ps2_scancode_decoder_if;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_extended;
   logic       key_released;
   logic       space_held;
   logic       jump;
   logic       prefix_timeout;

   modport master (
      output byte_data, byte_valid,
      input  key_valid, key_code, key_extended, key_released,
             space_held, jump, prefix_timeout
   );

   modport slave (
      input  byte_data, byte_valid,
      output key_valid, key_code, key_extended, key_released,
             space_held, jump, prefix_timeout
   );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder: synchronises the receiver strobe, strips E0/F0 prefixes,
// emits one-cycle key events and derives the space-bar jump pulse / held level.
module ps2_scancode_decoder #(
   parameter int         TIMEOUT_CYCLES = 500000,
   parameter logic [7:0] JUMP_CODE      = 8'h29
) (
   input  logic               clk,
   input  logic               rst,
   ps2_scancode_decoder_if.slave bus
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t        state, state_nxt;
   logic          s1, s2, s3;
   logic          byte_strobe;
   logic          ignored;
   logic          tmo_hit;
   logic [CW-1:0] tmo_cnt;
   logic          emit, emit_ext, emit_rel;

   // Three-flop synchroniser on the receiver strobe; s3 gives the rising-edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.byte_valid;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign byte_strobe = s2 & ~s3;
   assign ignored     = bus.byte_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                              8'hFC, 8'hFE, 8'hFF, 8'hE1};
   // A byte arriving on the expiry cycle wins over the timeout.
   assign tmo_hit     = (state != IDLE) && !byte_strobe &&
                        (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state and emit decode.
   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      emit_ext  = 1'b0;
      emit_rel  = 1'b0;
      if (byte_strobe) begin
         case (state)
            IDLE: begin
               if      (bus.byte_data == 8'hE0) state_nxt = EXT;
               else if (bus.byte_data == 8'hF0) state_nxt = BRK;
               else if (!ignored)               emit      = 1'b1;
            end
            EXT: begin
               if      (bus.byte_data == 8'hF0) state_nxt = EXT_BRK;
               else if (bus.byte_data == 8'hE0) state_nxt = EXT;
               else begin
                  state_nxt = IDLE;
                  emit      = !ignored;
                  emit_ext  = 1'b1;
               end
            end
            BRK: begin
               if      (bus.byte_data == 8'hF0) state_nxt = BRK;
               else if (bus.byte_data == 8'hE0) state_nxt = EXT_BRK;
               else begin
                  state_nxt = IDLE;
                  emit      = !ignored;
                  emit_rel  = 1'b1;
               end
            end
            EXT_BRK: begin
               if (bus.byte_data == 8'hE0 || bus.byte_data == 8'hF0) state_nxt = EXT_BRK;
               else begin
                  state_nxt = IDLE;
                  emit      = !ignored;
                  emit_ext  = 1'b1;
                  emit_rel  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else if (tmo_hit) begin
         state_nxt = IDLE;
      end
   end

   // Prefix-wait counter: runs only while a prefix is pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             tmo_cnt <= '0;
      else if (byte_strobe || state == IDLE) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + CW'(1);
   end

   // Registered event outputs and jump/held tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.key_valid      <= 1'b0;
         bus.key_code       <= 8'h00;
         bus.key_extended   <= 1'b0;
         bus.key_released   <= 1'b0;
         bus.space_held     <= 1'b0;
         bus.jump           <= 1'b0;
         bus.prefix_timeout <= 1'b0;
      end else begin
         bus.key_valid      <= emit;
         bus.jump           <= 1'b0;
         bus.prefix_timeout <= tmo_hit;
         if (emit) begin
            bus.key_code     <= bus.byte_data;
            bus.key_extended <= emit_ext;
            bus.key_released <= emit_rel;
            // Typematic repeats arrive as makes while held; only the first one jumps.
            if (bus.byte_data == JUMP_CODE && !emit_ext) begin
               if (emit_rel) begin
                  bus.space_held <= 1'b0;
               end else if (!bus.space_held) begin
                  bus.jump       <= 1'b1;
                  bus.space_held <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: stimulus pushes expected key events into a
// queue, an independent monitor pops and compares on every key_valid pulse.
module tb_ps2_scancode_decoder;
   localparam int T = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ps2_scancode_decoder_if bus();

   ps2_scancode_decoder #(.TIMEOUT_CYCLES(T), .JUMP_CODE(8'h29)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
      logic       jmp;
   } ev_t;

   ev_t exp_q[$];
   int  total    = 0;
   int  bad      = 0;
   int  tmo_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] outs();
      return {bus.key_valid, bus.key_code, bus.key_extended, bus.key_released,
              bus.space_held, bus.jump, bus.prefix_timeout};
   endfunction

   task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel,
                            input logic jmp);
      ev_t e;
      e.code = code; e.ext = ext; e.rel = rel; e.jmp = jmp;
      exp_q.push_back(e);
   endtask

   task automatic raise(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.byte_data  = b;
      bus.byte_valid = 1'b1;
   endtask

   task automatic finish_byte();
      repeat (4) @(posedge clk);
      #1 bus.byte_valid = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      raise(b);
      finish_byte();
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst && bus.key_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event act=%0h/%0b/%0b exp=none",
                     bus.key_code, bus.key_extended, bus.key_released);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("ev_code", bus.key_code, e.code);
            chk("ev_ext",  bus.key_extended, e.ext);
            chk("ev_rel",  bus.key_released, e.rel);
            chk("ev_jump", bus.jump, e.jmp);
         end
      end else if (rst && bus.jump) begin
         total++;
         bad++;
         $display("FAIL stray_jump act=1 exp=0");
      end
      if (rst && bus.prefix_timeout) tmo_seen++;
   end

   initial begin
      bus.byte_data  = 8'h00;
      bus.byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset_outs", outs(), 0);
      @(negedge clk) rst = 1'b1;

      // First press: latency and jump.
      expect_ev(8'h29, 1'b0, 1'b0, 1'b1);
      raise(8'h29);
      repeat (2) @(posedge clk);
      #1 chk("latency_early", bus.key_valid, 0);
      @(posedge clk);
      #1 chk("latency_kv", bus.key_valid, 1);
      chk("latency_jump", bus.jump, 1);
      @(posedge clk);
      #1 bus.byte_valid = 1'b0;
      repeat (6) @(posedge clk);
      chk("held_after_make", bus.space_held, 1);

      // Typematic repeat, then release.
      expect_ev(8'h29, 1'b0, 1'b0, 1'b0);
      send(8'h29);
      send(8'hF0);
      expect_ev(8'h29, 1'b0, 1'b1, 1'b0);
      send(8'h29);
      chk("held_after_break", bus.space_held, 0);

      // Extended make/break, and extended 29 leaves space_held alone.
      send(8'hE0);
      expect_ev(8'h75, 1'b1, 1'b0, 1'b0);
      send(8'h75);
      send(8'hE0);
      send(8'hF0);
      expect_ev(8'h75, 1'b1, 1'b1, 1'b0);
      send(8'h75);
      send(8'hE0);
      expect_ev(8'h29, 1'b1, 1'b0, 1'b0);
      send(8'h29);
      chk("held_ext29", bus.space_held, 0);

      // Prefix expires, following byte is a make.
      send(8'hF0);
      repeat (T + 10) @(posedge clk);
      chk("timeout_count", tmo_seen, 1);
      expect_ev(8'h1C, 1'b0, 1'b0, 1'b0);
      send(8'h1C);

      // Byte strobe on the expiry cycle wins over the timeout.
      raise(8'hF0);
      repeat (4) @(posedge clk);
      #1 bus.byte_valid = 1'b0;
      repeat (T - 4) @(posedge clk);
      #1;
      bus.byte_data  = 8'h1C;
      bus.byte_valid = 1'b1;
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b0);
      finish_byte();
      repeat (T + 5) @(posedge clk);
      chk("timeout_suppressed", tmo_seen, 1);

      // Ignored codes, including one that cancels a pending prefix.
      send(8'hFA);
      send(8'hAA);
      send(8'hE0);
      send(8'hFA);
      expect_ev(8'h1C, 1'b0, 1'b0, 1'b0);
      send(8'h1C);
      chk("hold_key_code", bus.key_code, 8'h1C);

      // Reset mid-prefix while space is held.
      expect_ev(8'h29, 1'b0, 1'b0, 1'b1);
      send(8'h29);
      chk("held_before_rst", bus.space_held, 1);
      send(8'hF0);
      @(posedge clk);
      #3 rst = 1'b0;
      #2 chk("rst_async_outs", outs(), 0);
      repeat (3) @(posedge clk);
      #1 chk("rst_hold_outs", outs(), 0);
      #3 rst = 1'b1;
      expect_ev(8'h29, 1'b0, 1'b0, 1'b1);
      send(8'h29);
      chk("held_after_rst", bus.space_held, 1);

      repeat (5) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("timeout_final", tmo_seen, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
